bcd_entry: RTL and testbench
============================

# bcd_entry

- Front-panel numeric entry block for the Basys3 signal generator.
- Turns four raw push-buttons into a 4-digit BCD value and a cursor position.
- BCD and CURSOR connect directly to the seven-segment display driver's BCD and DECIMAL inputs, so the decimal point marks the digit being edited.
- Sits between the board button pins and the frequency/amplitude setting registers.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a button level change (1 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles UP/DOWN must be held, from press acceptance, before auto-repeat starts.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat steps once repeating.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: reset; synchronous to CLK, active-high.
- BTN_UP, input, 1: raw pad, asynchronous, active-high.
- BTN_DOWN, input, 1: raw pad, asynchronous, active-high.
- BTN_LEFT, input, 1: raw pad, asynchronous, active-high.
- BTN_RIGHT, input, 1: raw pad, asynchronous, active-high.
- LOAD, input, 1: synchronous preset strobe.
- LOAD_BCD, input, 16: preset value, four BCD digits, [3:0] least significant.
- BCD, output, 16: current value, four BCD digits, each always 0–9.
- CURSOR, output, 2: selected digit, 0 = least significant.
- CHANGED, output, 1: one-cycle pulse when BCD takes a new value.

## Operation
Button conditioning, identical for each button:
- Two-flop synchronizer.
- Debounce counter:
  - Clears whenever the synced level equals the accepted level.
  - Otherwise increments.
  - On reaching DEBOUNCE_CYCLES-1 while still differing, the accepted level flips and the counter clears.
- A rising edge of the accepted level produces a one-cycle press pulse.

Value arithmetic, with step = 10^CURSOR (1, 10, 100, 1000):
- UP press: BCD = min(BCD + step, 9999).
- DOWN press: BCD = max(BCD − step, 0000).
- Arithmetic is decimal with carry/borrow across digits. Example: 0995 +10 → 1005.
- Saturation is not wrap-around. Example: 9950 +100 → 9999.

Cursor:
- LEFT press: CURSOR + 1, saturating at 3.
- RIGHT press: CURSOR − 1, saturating at 0.

Auto-repeat:
- One shared repeat counter; it runs only while exactly one of UP/DOWN is accepted-high.
- First repeat step fires REPEAT_DELAY cycles after press acceptance, then every REPEAT_PERIOD cycles.
- Releasing the button, or both buttons becoming accepted-high, clears the counter and stops repeat.

Simultaneous and priority rules:
- UP and DOWN press/repeat pulses in the same cycle: neither applied.
- LEFT and RIGHT in the same cycle: neither applied.
- A value step and a cursor move in the same cycle: both applied, and the step uses the pre-move CURSOR.
- LOAD overrides all value steps that cycle:
  - BCD ← LOAD_BCD, with any digit >9 clamped to 9.
  - CURSOR unchanged.
  - Cursor moves in the same cycle still apply.

CHANGED:
- Asserted for exactly one cycle, coincident with the first cycle BCD shows the new value.
- Only when the new value differs from the old. A saturated step or a LOAD of an identical value gives no pulse.

Reset (RST high at a CLK edge):
- BCD = 0000, CURSOR = 0, CHANGED = 0.
- Synchronizers, accepted levels, debounce and repeat counters all cleared.
- Reset during a held button: the button must be re-accepted, which produces a new press after DEBOUNCE_CYCLES.

## Timing
- Raw button high from edge k: accepted level rises at edge k+2+DEBOUNCE_CYCLES.
  - Press pulse is high during the following cycle.
  - BCD/CURSOR/CHANGED update at edge k+3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no press.
- LOAD sampled high at edge n: BCD valid after edge n, CHANGED high for the cycle after edge n.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package bcd_entry_pkg:
  - BCD digit width (4).
  - Max digit (9).
  - Max value constant 16'h9999.
  - Button index encoding UP=0, DOWN=1, LEFT=2, RIGHT=3.
- Sub-module button_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated four times.
- The top level holds the repeat counter, the BCD add/subtract-with-saturation logic and the cursor register.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Reset, then BTN_UP held 20 cycles with CURSOR=0 → BCD 0000→0001 exactly 7 cycles after the first high sample, CHANGED one pulse, then repeat steps to 0002 after 8 more cycles and every 3 cycles after that.
- BTN_UP pulsed high for 3 cycles, 5 times → no BCD change, CHANGED never asserted.
- LOAD 0995, LEFT press (CURSOR=1), UP press → BCD 1005. Then LOAD 9950, LEFT (CURSOR=2), UP → 9999 with CHANGED. UP again → 9999 with no CHANGED.
- LOAD 0003, CURSOR=0, DOWN ×5 → 0002, 0001, 0000, 0000, 0000, with CHANGED on the first three only. LOAD 16'hFA12 → BCD 9912.
- UP and DOWN raised on the same cycle and held → BCD unchanged, no repeat. LEFT ×5 → CURSOR saturates at 3. RIGHT and LEFT on the same cycle → CURSOR unchanged.
- RST asserted mid-repeat while UP is held → BCD 0000, CURSOR 0 the next cycle. The next press is accepted DEBOUNCE_CYCLES later → BCD 0001.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_entry_pkg
//  Description : Shared constants and BCD helper functions for the front-panel
//                numeric entry block (digit width, digit/value limits, button
//                index encoding, decimal step and digit clamp functions).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_entry_pkg;

   localparam int          c_DIGIT_W    = 4;
   localparam int          c_NUM_DIGITS = 4;
   localparam logic [3:0]  c_MAX_DIGIT  = 4'd9;
   localparam logic [15:0] c_MAX_VALUE  = 16'h9999;

   // Button index encoding inside the conditioned-button vectors
   localparam int          c_BTN_UP     = 0;
   localparam int          c_BTN_DOWN   = 1;
   localparam int          c_BTN_LEFT   = 2;
   localparam int          c_BTN_RIGHT  = 3;

   // Adds or subtracts 10^i_pos to a four-digit BCD value with a decimal
   // carry/borrow chain. A carry out of the top digit saturates to 9999,
   // a borrow out of the top digit saturates to 0000.
   function automatic logic [15:0] bcd_step(input logic [15:0] i_val,
                                            input logic [1:0]  i_pos,
                                            input logic        i_down);
      logic [15:0] w_res;
      logic [4:0]  w_dig;
      logic [4:0]  w_inc;
      logic        w_carry;
      w_res   = '0;
      w_carry = 1'b0;
      for (int i = 0; i < c_NUM_DIGITS; i++) begin
         w_inc = (i == int'(i_pos)) ? 5'd1 : 5'd0;
         w_dig = {1'b0, i_val[i*c_DIGIT_W +: c_DIGIT_W]};
         if (i_down) begin
            // Underflow shows up as bit 4 set (5-bit two's complement)
            w_dig   = w_dig - w_inc - {4'd0, w_carry};
            w_carry = w_dig[4];
            if (w_carry) begin
               w_dig = w_dig + 5'd10;
            end
         end else begin
            w_dig   = w_dig + w_inc + {4'd0, w_carry};
            w_carry = (w_dig > 5'd9);
            if (w_carry) begin
               w_dig = w_dig - 5'd10;
            end
         end
         w_res[i*c_DIGIT_W +: c_DIGIT_W] = w_dig[3:0];
      end
      if (w_carry) begin
         w_res = i_down ? 16'h0000 : c_MAX_VALUE;
      end
      return w_res;
   endfunction

   // Forces every digit above 9 down to 9
   function automatic logic [15:0] bcd_clamp(input logic [15:0] i_val);
      logic [15:0] w_res;
      w_res = i_val;
      for (int i = 0; i < c_NUM_DIGITS; i++) begin
         if (i_val[i*c_DIGIT_W +: c_DIGIT_W] > c_MAX_DIGIT) begin
            w_res[i*c_DIGIT_W +: c_DIGIT_W] = c_MAX_DIGIT;
         end
      end
      return w_res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchronizer, debounce counter and rising-edge press
//                pulse for one raw push-button pad.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_btn    - raw asynchronous button pad
//                o_level  - accepted (debounced) button level
//                o_press  - one-cycle pulse after the accepted level rises
//  Revision    : 1.0  initial release
// ============================================================================
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int              c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         r_sync;
   logic               r_level;
   logic               r_press;
   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= 2'b00;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_press <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_LAST) begin
            // Level has differed long enough: accept it
            r_level <= ~r_level;
            r_cnt   <= '0;
            r_press <= ~r_level;
         end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/bcd_entry.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_entry
//  Description : Front-panel numeric entry. Four push-buttons edit a 4-digit
//                BCD value with decimal saturating steps at a movable cursor,
//                with auto-repeat on UP/DOWN and a synchronous preset load.
//  Ports       : CLK       - system clock
//                RST       - synchronous active-high reset
//                BTN_UP/BTN_DOWN/BTN_LEFT/BTN_RIGHT - raw button pads
//                LOAD      - preset strobe
//                LOAD_BCD  - preset value (digits >9 clamped to 9)
//                BCD       - current value, four BCD digits
//                CURSOR    - digit being edited, 0 = least significant
//                CHANGED   - one-cycle pulse when BCD takes a new value
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_entry
   import bcd_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   input  logic        BTN_LEFT,
   input  logic        BTN_RIGHT,
   input  logic        LOAD,
   input  logic [15:0] LOAD_BCD,
   output logic [15:0] BCD,
   output logic [1:0]  CURSOR,
   output logic        CHANGED
);

   localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
   localparam logic [c_REP_W-1:0] c_REP_DELAY  = c_REP_W'(REPEAT_DELAY);
   localparam logic [c_REP_W-1:0] c_REP_PERIOD = c_REP_W'(REPEAT_PERIOD);

   logic [3:0]         w_raw;
   logic [3:0]         w_level;
   logic [3:0]         w_press;

   logic [c_REP_W-1:0] r_rep_cnt;
   logic               r_repeating;
   logic               w_rep_active;
   logic               w_rep_fire;

   logic               w_step_up;
   logic               w_step_dn;
   logic               w_move_l;
   logic               w_move_r;

   logic [15:0]        r_bcd;
   logic [1:0]         r_cursor;
   logic               r_changed;
   logic [15:0]        w_bcd_next;
   logic [1:0]         w_cursor_next;

   assign w_raw[c_BTN_UP]    = BTN_UP;
   assign w_raw[c_BTN_DOWN]  = BTN_DOWN;
   assign w_raw[c_BTN_LEFT]  = BTN_LEFT;
   assign w_raw[c_BTN_RIGHT] = BTN_RIGHT;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (CLK),
            .rst     (RST),
            .i_btn   (w_raw[gi]),
            .o_level (w_level[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   // Auto-repeat: the counter sits at 0 in the cycle after acceptance, so a
   // fire when it equals the delay lands the step REPEAT_DELAY cycles after
   // the press step; afterwards it restarts at 1 and fires at the period.
   assign w_rep_active = w_level[c_BTN_UP] ^ w_level[c_BTN_DOWN];
   assign w_rep_fire   = w_rep_active &&
                         (r_rep_cnt == (r_repeating ? c_REP_PERIOD : c_REP_DELAY));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rep_cnt   <= '0;
         r_repeating <= 1'b0;
      end else if (!w_rep_active) begin
         r_rep_cnt   <= '0;
         r_repeating <= 1'b0;
      end else if (w_rep_fire) begin
         r_rep_cnt   <= c_REP_W'(1);
         r_repeating <= 1'b1;
      end else begin
         r_rep_cnt   <= r_rep_cnt + c_REP_W'(1);
      end
   end

   assign w_step_up = w_press[c_BTN_UP]   | (w_rep_fire & w_level[c_BTN_UP]);
   assign w_step_dn = w_press[c_BTN_DOWN] | (w_rep_fire & w_level[c_BTN_DOWN]);
   assign w_move_l  = w_press[c_BTN_LEFT];
   assign w_move_r  = w_press[c_BTN_RIGHT];

   // Value step always uses the pre-move cursor; LOAD overrides steps only
   always_comb begin
      w_bcd_next    = r_bcd;
      w_cursor_next = r_cursor;
      if (LOAD) begin
         w_bcd_next = bcd_clamp(LOAD_BCD);
      end else if (w_step_up && !w_step_dn) begin
         w_bcd_next = bcd_step(r_bcd, r_cursor, 1'b0);
      end else if (w_step_dn && !w_step_up) begin
         w_bcd_next = bcd_step(r_bcd, r_cursor, 1'b1);
      end
      if (w_move_l && !w_move_r && (r_cursor != 2'd3)) begin
         w_cursor_next = r_cursor + 2'd1;
      end else if (w_move_r && !w_move_l && (r_cursor != 2'd0)) begin
         w_cursor_next = r_cursor - 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_bcd     <= 16'h0000;
         r_cursor  <= 2'd0;
         r_changed <= 1'b0;
      end else begin
         r_bcd     <= w_bcd_next;
         r_cursor  <= w_cursor_next;
         r_changed <= (w_bcd_next != r_bcd);
      end
   end

   assign BCD     = r_bcd;
   assign CURSOR  = r_cursor;
   assign CHANGED = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_entry
//  Description : Self-checking bench for bcd_entry (table of directed press /
//                load vectors plus hand-written timing sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_entry;

   localparam int OP_LOAD  = 0;
   localparam int OP_PRESS = 1;

   typedef struct {
      int          op;
      logic [3:0]  mask;      // [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
      int          hold;
      logic [15:0] val;
      logic [15:0] exp_bcd;
      logic [1:0]  exp_cur;
      int          exp_chg;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0;
   logic        LOAD = 1'b0;
   logic [15:0] LOAD_BCD = 16'h0000;
   logic [15:0] BCD;
   logic [1:0]  CURSOR;
   logic        CHANGED;

   int checks = 0;
   int errors = 0;
   vec_t vq[$];

   bcd_entry #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (3)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .BTN_UP    (BTN_UP),
      .BTN_DOWN  (BTN_DOWN),
      .BTN_LEFT  (BTN_LEFT),
      .BTN_RIGHT (BTN_RIGHT),
      .LOAD      (LOAD),
      .LOAD_BCD  (LOAD_BCD),
      .BCD       (BCD),
      .CURSOR    (CURSOR),
      .CHANGED   (CHANGED)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_btn(input logic [3:0] m);
      BTN_UP    = m[0];
      BTN_DOWN  = m[1];
      BTN_LEFT  = m[2];
      BTN_RIGHT = m[3];
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   // Press, hold, release and let everything settle; count CHANGED pulses
   task automatic press(input logic [3:0] m, input int hold, output int chg);
      chg = 0;
      drive_btn(m);
      for (int i = 0; i < hold; i++) begin
         tick();
         if (CHANGED) chg++;
      end
      drive_btn(4'b0000);
      for (int i = 0; i < 14; i++) begin
         tick();
         if (CHANGED) chg++;
      end
   endtask

   function automatic vec_t mk(input int op, input logic [3:0] m, input int hold,
                               input logic [15:0] val, input logic [15:0] eb,
                               input logic [1:0] ec, input int chg);
      vec_t v;
      v.op = op; v.mask = m; v.hold = hold; v.val = val;
      v.exp_bcd = eb; v.exp_cur = ec; v.exp_chg = chg;
      return v;
   endfunction

   initial begin
      int chg;
      int exp_val;
      bit is_upd;

      // ---- vector table ------------------------------------------------
      vq.push_back(mk(OP_LOAD,  4'b0000, 0,  16'h0995, 16'h0995, 2'd0, 1));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h0995, 2'd1, 0));
      vq.push_back(mk(OP_PRESS, 4'b0001, 6,  16'h0,    16'h1005, 2'd1, 1));
      vq.push_back(mk(OP_LOAD,  4'b0000, 0,  16'h9950, 16'h9950, 2'd1, 1));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h9950, 2'd2, 0));
      vq.push_back(mk(OP_PRESS, 4'b0001, 6,  16'h0,    16'h9999, 2'd2, 1));
      vq.push_back(mk(OP_PRESS, 4'b0001, 6,  16'h0,    16'h9999, 2'd2, 0));
      vq.push_back(mk(OP_LOAD,  4'b0000, 0,  16'h0003, 16'h0003, 2'd2, 1));
      vq.push_back(mk(OP_PRESS, 4'b1000, 6,  16'h0,    16'h0003, 2'd1, 0));
      vq.push_back(mk(OP_PRESS, 4'b1000, 6,  16'h0,    16'h0003, 2'd0, 0));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0002, 2'd0, 1));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0001, 2'd0, 1));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0000, 2'd0, 1));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0000, 2'd0, 0));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0000, 2'd0, 0));
      vq.push_back(mk(OP_LOAD,  4'b0000, 0,  16'hFA12, 16'h9912, 2'd0, 1));
      vq.push_back(mk(OP_PRESS, 4'b0011, 16, 16'h0,    16'h9912, 2'd0, 0));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h9912, 2'd1, 0));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h9912, 2'd2, 0));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h9912, 2'd3, 0));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h9912, 2'd3, 0));
      vq.push_back(mk(OP_PRESS, 4'b0100, 6,  16'h0,    16'h9912, 2'd3, 0));
      vq.push_back(mk(OP_PRESS, 4'b1100, 6,  16'h0,    16'h9912, 2'd3, 0));
      vq.push_back(mk(OP_PRESS, 4'b1000, 6,  16'h0,    16'h9912, 2'd2, 0));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h9812, 2'd2, 1));
      vq.push_back(mk(OP_PRESS, 4'b0110, 6,  16'h0,    16'h9712, 2'd3, 1));
      vq.push_back(mk(OP_LOAD,  4'b0000, 0,  16'h9712, 16'h9712, 2'd3, 0));
      vq.push_back(mk(OP_PRESS, 4'b0001, 6,  16'h0,    16'h9999, 2'd3, 1));
      vq.push_back(mk(OP_LOAD,  4'b0000, 0,  16'h1000, 16'h1000, 2'd3, 1));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0000, 2'd3, 1));
      vq.push_back(mk(OP_PRESS, 4'b0010, 6,  16'h0,    16'h0000, 2'd3, 0));

      // ---- reset state -------------------------------------------------
      do_reset();
      check("reset_bcd", 32'(BCD), 32'h0);
      check("reset_cursor", 32'(CURSOR), 32'h0);
      check("reset_changed", 32'(CHANGED), 32'h0);

      // ---- UP held 20 cycles: first step 7 edges after drive, repeat
      //      8 edges later then every 3 edges until the level drops ------
      tick();
      BTN_UP = 1'b1;
      exp_val = 0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         is_upd = (n == 7) || (n == 15) || (n == 18) || (n == 21) || (n == 24);
         if (is_upd) exp_val++;
         check($sformatf("hold_bcd_e%0d", n), 32'(BCD), 32'(exp_val));
         check($sformatf("hold_changed_e%0d", n), 32'(CHANGED), 32'(is_upd));
         if (n == 20) BTN_UP = 1'b0;
      end

      // ---- short glitches: no press ------------------------------------
      chg = 0;
      for (int p = 0; p < 5; p++) begin
         BTN_UP = 1'b1;
         for (int i = 0; i < 3; i++) begin tick(); if (CHANGED) chg++; end
         BTN_UP = 1'b0;
         for (int i = 0; i < 5; i++) begin tick(); if (CHANGED) chg++; end
      end
      for (int i = 0; i < 10; i++) begin tick(); if (CHANGED) chg++; end
      check("glitch_changed_count", 32'(chg), 32'h0);
      check("glitch_bcd", 32'(BCD), 32'h5);

      // ---- table-driven vectors -----------------------------------------
      do_reset();
      tick();
      foreach (vq[k]) begin
         if (vq[k].op == OP_LOAD) begin
            LOAD = 1'b1;
            LOAD_BCD = vq[k].val;
            tick();
            LOAD = 1'b0;
            check($sformatf("v%0d_load_bcd", k), 32'(BCD), 32'(vq[k].exp_bcd));
            check($sformatf("v%0d_load_changed", k), 32'(CHANGED), 32'(vq[k].exp_chg));
            check($sformatf("v%0d_load_cursor", k), 32'(CURSOR), 32'(vq[k].exp_cur));
            tick();
            check($sformatf("v%0d_changed_drop", k), 32'(CHANGED), 32'h0);
         end else begin
            press(vq[k].mask, vq[k].hold, chg);
            check($sformatf("v%0d_bcd", k), 32'(BCD), 32'(vq[k].exp_bcd));
            check($sformatf("v%0d_cursor", k), 32'(CURSOR), 32'(vq[k].exp_cur));
            check($sformatf("v%0d_changes", k), 32'(chg), 32'(vq[k].exp_chg));
         end
      end

      // ---- reset mid-repeat with UP still held (cursor 3, value 0000) ----
      BTN_UP = 1'b1;
      for (int n = 1; n <= 16; n++) tick();
      check("prereset_bcd", 32'(BCD), 32'h2000);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("midrst_bcd", 32'(BCD), 32'h0);
      check("midrst_cursor", 32'(CURSOR), 32'h0);
      check("midrst_changed", 32'(CHANGED), 32'h0);
      for (int j = 1; j <= 7; j++) begin
         tick();
         if (j == 6) check("rearm_bcd_before", 32'(BCD), 32'h0);
      end
      check("rearm_bcd", 32'(BCD), 32'h1);
      check("rearm_changed", 32'(CHANGED), 32'h1);
      BTN_UP = 1'b0;
      for (int i = 0; i < 14; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
